// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared constants and types for the square-root result checker.
//   NUM_W     : radicand width
//   ROOT_W    : root width as delivered by the square-root engine
//   HALF_W    : significant root width (NUM_W/2)
//   ERR_CNT_W : width of the saturating error counter
//   CNT_W     : width of the multiplier bit counter (log2(HALF_W))
// -----------------------------------------------------------------------------
package sqrt_pkg;

    localparam int NUM_W     = 64;
    localparam int ROOT_W    = 128;
    localparam int HALF_W    = NUM_W / 2;
    localparam int ERR_CNT_W = 16;
    localparam int CNT_W     = $clog2(HALF_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } sqrt_chk_state_t;

endpackage

// File: rtl/sqrt_chk_mul32.sv
// -----------------------------------------------------------------------------
// sqrt_chk_mul32
// Sequential shift-add squarer: accumulates operand*operand one multiplier
// bit per cycle over HALF_W cycles after a start pulse.
// Ports:
//   clk       in  : clock, rising edge
//   rst       in  : synchronous active-high reset
//   start_i   in  : load operand, clear accumulator and counter
//   operand_i in  : HALF_W-bit value to square
//   acc_o     out : NUM_W-bit accumulator (operand^2 once the run completes)
//   done_o    out : high in the cycle whose edge processes the last bit
// -----------------------------------------------------------------------------
module sqrt_chk_mul32
    import sqrt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [HALF_W-1:0] operand_i,
    output logic [NUM_W-1:0]  acc_o,
    output logic              done_o
);

    logic [HALF_W-1:0] op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;
    logic [NUM_W-1:0]  acc_q;
    logic [NUM_W-1:0]  acc_d;
    logic [NUM_W-1:0]  partial;

    // The operand is both multiplicand and multiplier: add op << i when bit i is set.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        acc_d   = acc_q;
        partial = {{(NUM_W-HALF_W){1'b0}}, op_q} << cnt_q;
        if (op_q[cnt_q]) begin
            acc_d = acc_q + partial;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            op_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            acc_q <= '0;
        end else if (start_i) begin
            op_q  <= operand_i;
            cnt_q <= '0;
            run_q <= 1'b1;
            acc_q <= '0;
        end else if (run_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(HALF_W-1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign acc_o  = acc_q;
    assign done_o = run_q && (cnt_q == CNT_W'(HALF_W-1));

endmodule

// File: rtl/sqrt_result_check.sv
// -----------------------------------------------------------------------------
// sqrt_result_check
// Verifies that a root delivered by the 64-bit square-root engine is the exact
// floor square root of its radicand: squares the root sequentially, then
// applies r^2 <= num < (r+1)^2, i.e. acc <= num and num - acc <= 2r.
// Optional feature macro: SQRT_CHK_REM_EN adds the out_rem port (num - r^2).
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   in_valid/in_ready  : input handshake (ready only in IDLE)
//   in_num, in_root    : radicand and root under test
//   out_valid/out_ready: verdict handshake (valid only in DONE)
//   out_pass, out_exact: floor-root verdict, and perfect-square flag
//   out_rem            : remainder when pass, else 0 (SQRT_CHK_REM_EN only)
//   err_cnt            : saturating count of failed checks
//   busy               : FSM not in IDLE
// -----------------------------------------------------------------------------
module sqrt_result_check
    import sqrt_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_W-1:0]     in_num,
    input  logic [ROOT_W-1:0]    in_root,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_pass,
    output logic                 out_exact,
`ifdef SQRT_CHK_REM_EN
    output logic [NUM_W-1:0]     out_rem,
`endif
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    sqrt_chk_state_t state_q, state_d;

    logic              accept;
    logic              root_hi_nz;
    logic              mul_start;
    logic              mul_done;
    logic [NUM_W-1:0]  mul_acc;

    logic [NUM_W-1:0]     num_q;
    logic [HALF_W-1:0]    root_q;
    logic                 fastfail_q;
    logic                 pass_q;
    logic                 exact_q;
    logic [ERR_CNT_W-1:0] err_q;
`ifdef SQRT_CHK_REM_EN
    logic [NUM_W-1:0]     rem_q;
`endif

    logic [NUM_W:0]    num_ext;
    logic [NUM_W:0]    acc_ext;
    logic [NUM_W:0]    diff;
    logic [HALF_W:0]   two_r;
    logic              pass_d;
    logic              exact_d;

    // A root with any bit set above HALF_W cannot be the floor root of an
    // NUM_W-bit radicand, so it skips the multiplier entirely.
    assign root_hi_nz = |in_root[ROOT_W-1:HALF_W];
    assign accept     = in_valid && in_ready;

    sqrt_chk_mul32 u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .operand_i (in_root[HALF_W-1:0]),
        .acc_o     (mul_acc),
        .done_o    (mul_done)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)    state_d = root_hi_nz ? CMP : MUL;
            MUL:  if (mul_done)  state_d = CMP;
            CMP:                 state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        mul_start = (state_q == IDLE) && in_valid && !root_hi_nz;
    end

    // ---------------- Window comparison (65-bit unsigned) ----------------
    always_comb begin
        num_ext = {1'b0, num_q};
        acc_ext = {1'b0, mul_acc};
        diff    = num_ext - acc_ext;
        two_r   = {root_q, 1'b0};
        pass_d  = !fastfail_q
                  && (acc_ext <= num_ext)
                  && (diff <= {{(NUM_W-HALF_W){1'b0}}, two_r});
        exact_d = pass_d && (mul_acc == num_q);
    end

    // ---------------- Operand capture and verdict registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q      <= '0;
            root_q     <= '0;
            fastfail_q <= 1'b0;
            pass_q     <= 1'b0;
            exact_q    <= 1'b0;
            err_q      <= '0;
`ifdef SQRT_CHK_REM_EN
            rem_q      <= '0;
`endif
        end else begin
            if (accept) begin
                num_q      <= in_num;
                root_q     <= in_root[HALF_W-1:0];
                fastfail_q <= root_hi_nz;
            end
            if (state_q == CMP) begin
                pass_q  <= pass_d;
                exact_q <= exact_d;
`ifdef SQRT_CHK_REM_EN
                rem_q   <= pass_d ? diff[NUM_W-1:0] : '0;
`endif
                if (!pass_d && (err_q != {ERR_CNT_W{1'b1}})) begin
                    err_q <= err_q + 1'b1;
                end
            end
        end
    end

    assign out_pass  = pass_q;
    assign out_exact = exact_q;
    assign err_cnt   = err_q;
`ifdef SQRT_CHK_REM_EN
    assign out_rem   = rem_q;
`endif

endmodule

// File: tb/tb_sqrt_result_check.sv
module tb_sqrt_result_check;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_num;
    logic [127:0] in_root;
    logic         out_valid;
    logic         out_ready;
    logic         out_pass;
    logic         out_exact;
`ifdef SQRT_CHK_REM_EN
    logic [63:0]  out_rem;
`endif
    logic [15:0]  err_cnt;
    logic         busy;

    int passed = 0;
    int total  = 0;

    sqrt_result_check dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_root   (in_root),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pass  (out_pass),
        .out_exact (out_exact),
`ifdef SQRT_CHK_REM_EN
        .out_rem   (out_rem),
`endif
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one pair at a negedge; the following posedge is the acceptance edge.
    task automatic accept_pair(input logic [63:0] num, input logic [127:0] root);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
        else passed++;
        in_valid = 1'b1;
        in_num   = num;
        in_root  = root;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Latency counts the acceptance cycle: out_valid seen after edge k gives k+1.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = i + 1;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic release_pair();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_pair(input logic [63:0] num, input logic [127:0] root, output int lat);
        accept_pair(num, root);
        wait_valid(lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_num = '0; in_root = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (in_ready !== 1'b1)  $display("FAIL rst_in_ready: got %b expected 1", in_ready);   else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passed++;
        total++; if (busy !== 1'b0)      $display("FAIL rst_busy: got %b expected 0", busy);           else passed++;
        total++; if (err_cnt !== 16'd0)  $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt);   else passed++;
        total++; if (out_pass !== 1'b0)  $display("FAIL rst_pass: got %b expected 0", out_pass);       else passed++;
        total++; if (out_exact !== 1'b0) $display("FAIL rst_exact: got %b expected 0", out_exact);     else passed++;
`ifdef SQRT_CHK_REM_EN
        total++; if (out_rem !== 64'd0)  $display("FAIL rst_rem: got %0h expected 0", out_rem);        else passed++;
`endif
    endtask

    task automatic test_exact_square();
        int lat;
        run_pair(64'd144, 128'd12, lat);
        total++; if (lat !== 34)         $display("FAIL exact_latency: got %0d expected 34", lat);     else passed++;
        total++; if (out_pass !== 1'b1)  $display("FAIL exact_pass: got %b expected 1", out_pass);     else passed++;
        total++; if (out_exact !== 1'b1) $display("FAIL exact_exact: got %b expected 1", out_exact);   else passed++;
        total++; if (busy !== 1'b1)      $display("FAIL exact_busy: got %b expected 1", busy);         else passed++;
        total++; if (err_cnt !== 16'd0)  $display("FAIL exact_err: got %0d expected 0", err_cnt);     else passed++;
`ifdef SQRT_CHK_REM_EN
        total++; if (out_rem !== 64'd0)  $display("FAIL exact_rem: got %0h expected 0", out_rem);      else passed++;
`endif
        release_pair();
    endtask

    task automatic test_inexact();
        int lat;
        run_pair(64'd150, 128'd12, lat);
        total++; if (lat !== 34)         $display("FAIL inexact_latency: got %0d expected 34", lat);   else passed++;
        total++; if (out_pass !== 1'b1)  $display("FAIL inexact_pass: got %b expected 1", out_pass);   else passed++;
        total++; if (out_exact !== 1'b0) $display("FAIL inexact_exact: got %b expected 0", out_exact); else passed++;
`ifdef SQRT_CHK_REM_EN
        total++; if (out_rem !== 64'd6)  $display("FAIL inexact_rem: got %0h expected 6", out_rem);    else passed++;
`endif
        release_pair();
    endtask

    task automatic test_fail_count();
        int lat;
        // 13^2 = 169 > 150
        run_pair(64'd150, 128'd13, lat);
        total++; if (out_pass !== 1'b0)  $display("FAIL high_root_pass: got %b expected 0", out_pass); else passed++;
        total++; if (out_exact !== 1'b0) $display("FAIL high_root_exact: got %b expected 0", out_exact); else passed++;
        total++; if (err_cnt !== 16'd1)  $display("FAIL high_root_err: got %0d expected 1", err_cnt);  else passed++;
`ifdef SQRT_CHK_REM_EN
        total++; if (out_rem !== 64'd0)  $display("FAIL high_root_rem: got %0h expected 0", out_rem);  else passed++;
`endif
        release_pair();
        // 11^2 = 121, 150-121 = 29 > 22
        run_pair(64'd150, 128'd11, lat);
        total++; if (out_pass !== 1'b0)  $display("FAIL low_root_pass: got %b expected 0", out_pass);  else passed++;
        total++; if (err_cnt !== 16'd2)  $display("FAIL low_root_err: got %0d expected 2", err_cnt);   else passed++;
        release_pair();
    endtask

    task automatic test_upper_edge();
        int lat;
        // (2^32-1)^2 = 0xFFFFFFFE00000001, remainder 0x1FFFFFFFE == 2r exactly
        run_pair(64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF, lat);
        total++; if (out_pass !== 1'b1)  $display("FAIL edge_pass: got %b expected 1", out_pass);      else passed++;
        total++; if (out_exact !== 1'b0) $display("FAIL edge_exact: got %b expected 0", out_exact);    else passed++;
        total++; if (err_cnt !== 16'd2)  $display("FAIL edge_err: got %0d expected 2", err_cnt);       else passed++;
`ifdef SQRT_CHK_REM_EN
        total++; if (out_rem !== 64'h1_FFFF_FFFE) $display("FAIL edge_rem: got %0h expected 1fffffffe", out_rem); else passed++;
`endif
        release_pair();
    endtask

    task automatic test_fast_fail();
        int lat;
        logic [127:0] big_root;
        big_root = 128'd1 << 32;
        run_pair(64'hFFFF_FFFF_FFFF_FFFF, big_root, lat);
        total++; if (lat !== 2)          $display("FAIL fast_latency: got %0d expected 2", lat);       else passed++;
        total++; if (out_pass !== 1'b0)  $display("FAIL fast_pass: got %b expected 0", out_pass);      else passed++;
        total++; if (err_cnt !== 16'd3)  $display("FAIL fast_err: got %0d expected 3", err_cnt);       else passed++;
        release_pair();
    endtask

    task automatic test_backpressure();
        int lat;
        run_pair(64'd144, 128'd12, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_pass !== 1'b1 || out_exact !== 1'b1 || in_ready !== 1'b0 || err_cnt !== 16'd3)
                $display("FAIL bp_hold cycle %0d: valid=%b pass=%b exact=%b in_ready=%b err=%0d expected 1 1 1 0 3",
                         c, out_valid, out_pass, out_exact, in_ready, err_cnt);
            else passed++;
        end
        release_pair();
        total++; if (in_ready !== 1'b1)  $display("FAIL bp_release_ready: got %b expected 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_mid_mul_reset();
        int lat;
        accept_pair(64'd150, 128'd13);
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else passed++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL mrst_valid: got %b expected 0", out_valid);    else passed++;
        total++; if (in_ready !== 1'b1)  $display("FAIL mrst_ready: got %b expected 1", in_ready);     else passed++;
        total++; if (err_cnt !== 16'd0)  $display("FAIL mrst_err: got %0d expected 0", err_cnt);      else passed++;
        total++; if (busy !== 1'b0)      $display("FAIL mrst_busy: got %b expected 0", busy);         else passed++;
        rst = 1'b0;
        run_pair(64'd144, 128'd12, lat);
        total++; if (lat !== 34)         $display("FAIL recover_latency: got %0d expected 34", lat);   else passed++;
        total++; if (out_pass !== 1'b1)  $display("FAIL recover_pass: got %b expected 1", out_pass);   else passed++;
        total++; if (err_cnt !== 16'd0)  $display("FAIL recover_err: got %0d expected 0", err_cnt);   else passed++;
        release_pair();
    endtask

    initial begin
        test_reset();
        test_exact_square();
        test_inexact();
        test_fail_count();
        test_upper_edge();
        test_fast_fail();
        test_backpressure();
        test_mid_mul_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
